// File: rtl/cpu_pkg.sv
// Shared definitions for the program sequencer: flow-command encodings and
// sequencer state encoding.
package cpu_pkg;

  localparam logic [2:0] CMD_NEXT = 3'b000;
  localparam logic [2:0] CMD_JMP  = 3'b001;
  localparam logic [2:0] CMD_JREL = 3'b010;
  localparam logic [2:0] CMD_JZ   = 3'b011;
  localparam logic [2:0] CMD_JNZ  = 3'b100;
  localparam logic [2:0] CMD_CALL = 3'b101;
  localparam logic [2:0] CMD_RET  = 3'b110;
  localparam logic [2:0] CMD_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

endpackage

// File: rtl/cpu_ras.sv
// Return-address stack: LIFO of DEPTH entries with occupancy counter.
// PUSH is ignored when full and POP when empty.
module cpu_ras #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic [WIDTH-1:0]           DIN,
  output logic [WIDTH-1:0]           TOS,
  output logic [$clog2(DEPTH+1)-1:0] SP,
  output logic                       FULL,
  output logic                       EMPTY
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    tos_idx;

  assign FULL    = (SP == SPW'(DEPTH));
  assign EMPTY   = (SP == '0);
  assign tos_idx = IW'(SP - SPW'(1));
  assign TOS     = EMPTY ? '0 : mem[tos_idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SP <= '0;
    end else if (PUSH && !FULL) begin
      SP <= SP + SPW'(1);
    end else if (POP && !EMPTY) begin
      SP <= SP - SPW'(1);
    end
  end

  // NOTE: the entry storage has no reset; slots above SP are never read, so
  // clearing them would only cost reset fan-out.
  always_ff @(posedge CLK) begin
    if (PUSH && !FULL) begin
      mem[IW'(SP)] <= DIN;
    end
  end

endmodule

// File: rtl/cpu_seq.sv
// Program sequencer: PC register, next-PC selection (absolute, relative,
// conditional, call/return) and the RUN/HALT/FAULT state machine.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int                AWIDTH    = 8,
  parameter int                DEPTH     = 4,
  parameter logic [AWIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN,
  input  logic [2:0]                 CMD,
  input  logic [AWIDTH-1:0]          TARGET,
  input  logic                       Z,
  input  logic                       RESUME,
  output logic [AWIDTH-1:0]          PC,
  output logic [$clog2(DEPTH+1)-1:0] SP,
  output logic                       HALTED,
  output logic                       FAULT
);

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] pc_nxt, pc_inc, tos;
  logic              push, pop, full, empty;

  assign pc_inc = PC + AWIDTH'(1);

  cpu_ras #(
    .WIDTH (AWIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .RST_N (RST_N),
    .PUSH  (push),
    .POP   (pop),
    .DIN   (pc_inc),
    .TOS   (tos),
    .SP    (SP),
    .FULL  (full),
    .EMPTY (empty)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_nxt    = PC;
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    if (EN) begin
      unique case (state)
        ST_RUN: begin
          unique case (CMD)
            CMD_NEXT: pc_nxt = pc_inc;
            CMD_JMP:  pc_nxt = TARGET;
            // Same-width add is the sign-extended offset taken modulo 2^AWIDTH.
            CMD_JREL: pc_nxt = PC + TARGET;
            CMD_JZ:   pc_nxt = Z ? TARGET : pc_inc;
            CMD_JNZ:  pc_nxt = Z ? pc_inc : TARGET;
            CMD_CALL: begin
              if (full) begin
                state_nxt = ST_FAULT;
              end else begin
                push   = 1'b1;
                pc_nxt = TARGET;
              end
            end
            CMD_RET: begin
              if (empty) begin
                state_nxt = ST_FAULT;
              end else begin
                pop    = 1'b1;
                pc_nxt = tos;
              end
            end
            default:  state_nxt = ST_HALT;
          endcase
        end
        ST_HALT: begin
          if (RESUME) begin
            pc_nxt    = pc_inc;
            state_nxt = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC     <= RESET_VEC;
      state  <= ST_RUN;
      HALTED <= 1'b0;
      FAULT  <= 1'b0;
    end else begin
      PC     <= pc_nxt;
      state  <= state_nxt;
      HALTED <= (state_nxt == ST_HALT);
      FAULT  <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq (AWIDTH=8, DEPTH=4, RESET_VEC=0) with
// hand-computed expected PC/SP/flag values.
module tb_cpu_seq;
  import cpu_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN;
  logic [2:0] CMD;
  logic [7:0] TARGET;
  logic       Z;
  logic       RESUME;
  logic [7:0] PC;
  logic [2:0] SP;
  logic       HALTED;
  logic       FAULT;

  int total = 0;
  int bad   = 0;

  cpu_seq #(
    .AWIDTH    (8),
    .DEPTH     (4),
    .RESET_VEC (8'h00)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .CMD    (CMD),
    .TARGET (TARGET),
    .Z      (Z),
    .RESUME (RESUME),
    .PC     (PC),
    .SP     (SP),
    .HALTED (HALTED),
    .FAULT  (FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one instruction across one rising edge; outputs are read 1ns later.
  task automatic step(input logic [2:0] c, input logic [7:0] t, input logic z,
                      input logic en, input logic res);
    CMD    = c;
    TARGET = t;
    Z      = z;
    EN     = en;
    RESUME = res;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    EN    = 1'b0;
    #1;
    check("rst_pc", PC, 8'h00);
    check("rst_sp", SP, 3'd0);
    check("rst_fault", FAULT, 1'b0);
    check("rst_halted", HALTED, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N  = 1'b0;
    EN     = 1'b0;
    CMD    = CMD_NEXT;
    TARGET = '0;
    Z      = 1'b0;
    RESUME = 1'b0;
    #12;
    do_reset();

    // Sequential fetch
    for (int i = 1; i <= 5; i++) begin
      step(CMD_NEXT, 8'h00, 1'b0, 1'b1, 1'b0);
      check("next_pc", PC, 32'(i));
    end
    check("next_sp", SP, 3'd0);
    check("next_halted", HALTED, 1'b0);
    check("next_fault", FAULT, 1'b0);

    // Absolute, relative, wrap
    step(CMD_JMP, 8'h10, 1'b0, 1'b1, 1'b0);  check("jmp", PC, 8'h10);
    step(CMD_JREL, 8'hFC, 1'b0, 1'b1, 1'b0); check("jrel_back", PC, 8'h0C);
    step(CMD_JREL, 8'h05, 1'b0, 1'b1, 1'b0); check("jrel_fwd", PC, 8'h11);
    step(CMD_JMP, 8'hFF, 1'b0, 1'b1, 1'b0);  check("jmp_ff", PC, 8'hFF);
    step(CMD_NEXT, 8'h00, 1'b0, 1'b1, 1'b0); check("wrap", PC, 8'h00);

    // Conditional jumps
    step(CMD_JZ, 8'h40, 1'b0, 1'b1, 1'b0);  check("jz_nt", PC, 8'h01);
    step(CMD_JZ, 8'h40, 1'b1, 1'b1, 1'b0);  check("jz_t", PC, 8'h40);
    step(CMD_JMP, 8'h05, 1'b0, 1'b1, 1'b0);
    step(CMD_JNZ, 8'h40, 1'b1, 1'b1, 1'b0); check("jnz_nt", PC, 8'h06);
    step(CMD_JNZ, 8'h40, 1'b0, 1'b1, 1'b0); check("jnz_t", PC, 8'h40);

    // Nested calls and returns
    step(CMD_JMP, 8'h01, 1'b0, 1'b1, 1'b0);
    step(CMD_CALL, 8'h21, 1'b0, 1'b1, 1'b0); check("call1_pc", PC, 8'h21); check("call1_sp", SP, 3'd1);
    step(CMD_CALL, 8'h31, 1'b0, 1'b1, 1'b0); check("call2_pc", PC, 8'h31); check("call2_sp", SP, 3'd2);
    step(CMD_CALL, 8'h41, 1'b0, 1'b1, 1'b0); check("call3_pc", PC, 8'h41); check("call3_sp", SP, 3'd3);
    step(CMD_CALL, 8'h50, 1'b0, 1'b1, 1'b0); check("call4_pc", PC, 8'h50); check("call4_sp", SP, 3'd4);
    check("call4_fault", FAULT, 1'b0);
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b0);  check("ret1_pc", PC, 8'h42); check("ret1_sp", SP, 3'd3);
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b0);  check("ret2_pc", PC, 8'h32); check("ret2_sp", SP, 3'd2);
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b0);  check("ret3_pc", PC, 8'h22); check("ret3_sp", SP, 3'd1);
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b0);  check("ret4_pc", PC, 8'h02); check("ret4_sp", SP, 3'd0);

    // Back-to-back call/return and wrapped return address
    step(CMD_CALL, 8'h80, 1'b0, 1'b1, 1'b0); check("b2b_call", PC, 8'h80);
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b0);  check("b2b_ret", PC, 8'h03);
    step(CMD_JMP, 8'hFF, 1'b0, 1'b1, 1'b0);
    step(CMD_CALL, 8'h10, 1'b0, 1'b1, 1'b0); check("wrap_call", PC, 8'h10);
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b0);  check("wrap_ret", PC, 8'h00);

    // Overflow
    step(CMD_CALL, 8'h11, 1'b0, 1'b1, 1'b0);
    step(CMD_CALL, 8'h22, 1'b0, 1'b1, 1'b0);
    step(CMD_CALL, 8'h33, 1'b0, 1'b1, 1'b0);
    step(CMD_CALL, 8'h44, 1'b0, 1'b1, 1'b0);
    step(CMD_CALL, 8'h55, 1'b0, 1'b1, 1'b0);
    check("ovf_fault", FAULT, 1'b1);
    check("ovf_pc", PC, 8'h44);
    check("ovf_sp", SP, 3'd4);
    check("ovf_halted", HALTED, 1'b0);
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b1);
    check("ovf_frozen_pc", PC, 8'h44);
    check("ovf_frozen_sp", SP, 3'd4);
    check("ovf_frozen_fault", FAULT, 1'b1);
    do_reset();

    // HALT / RESUME / stall
    step(CMD_JMP, 8'h07, 1'b0, 1'b1, 1'b0);
    step(CMD_HALT, 8'h00, 1'b0, 1'b1, 1'b0);
    check("halt_flag", HALTED, 1'b1);
    check("halt_pc", PC, 8'h07);
    for (int i = 0; i < 10; i++) begin
      step(CMD_JMP, 8'h60, 1'b0, 1'b1, 1'b0);
      check("halt_hold_pc", PC, 8'h07);
    end
    step(CMD_NEXT, 8'h00, 1'b0, 1'b0, 1'b1);
    check("resume_stall_pc", PC, 8'h07);
    check("resume_stall_halted", HALTED, 1'b1);
    step(CMD_JMP, 8'h60, 1'b0, 1'b1, 1'b1);
    check("resume_pc", PC, 8'h08);
    check("resume_halted", HALTED, 1'b0);
    step(CMD_JMP, 8'h30, 1'b0, 1'b0, 1'b0);
    check("stall_jmp", PC, 8'h08);
    step(CMD_NEXT, 8'h00, 1'b0, 1'b1, 1'b0);
    check("post_stall", PC, 8'h09);

    // Underflow
    step(CMD_RET, 8'h00, 1'b0, 1'b1, 1'b0);
    check("udf_fault", FAULT, 1'b1);
    check("udf_pc", PC, 8'h09);
    check("udf_sp", SP, 3'd0);
    step(CMD_JMP, 8'h70, 1'b0, 1'b1, 1'b1);
    step(CMD_CALL, 8'h70, 1'b0, 1'b1, 1'b0);
    check("udf_frozen_pc", PC, 8'h09);
    check("udf_frozen_sp", SP, 3'd0);
    check("udf_frozen_fault", FAULT, 1'b1);
    do_reset();
    step(CMD_NEXT, 8'h00, 1'b0, 1'b1, 1'b0);
    check("after_reset_pc", PC, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Parametrised program sequencer replacing the fixed PC / jump / single link-register arrangement of the one-cycle CPU. It owns the program counter, a return-address stack of configurable depth (nested CALL/RET), absolute, PC-relative and conditional jumps, a fetch stall, and a HALT/FAULT state machine. It sits between the instruction decoder (which supplies `CMD`, `TARGET`) and the instruction ROM (which consumes `PC`).

## Interface
- `AWIDTH`, 8, program address width (ROM depth 2^AWIDTH)
- `DEPTH`, 4, return-stack entries (≥1)
- `RESET_VEC`, 0, PC value after reset
- `CLK`  in  1  clock, rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `EN`  in  1  advance enable; 0 = stall, all state frozen
- `CMD`  in  3  flow command for the instruction at `PC`
- `TARGET`  in  AWIDTH  absolute address, or two's-complement offset for JREL
- `Z`  in  1  ALU zero flag
- `RESUME`  in  1  leave HALT
- `PC`  out  AWIDTH  registered fetch address
- `SP`  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH
- `HALTED`  out  1  state == HALT
- `FAULT`  out  1  state == FAULT (stack overflow/underflow)

## Operation
- CMD encoding: 000 NEXT, 001 JMP, 010 JREL, 011 JZ, 100 JNZ, 101 CALL, 110 RET, 111 HALT.
- States: RUN, HALT, FAULT. Reset → RUN.
- RUN, EN=1, next PC:
  - NEXT: PC+1.
  - JMP: TARGET.
  - JREL: PC + sign-extended TARGET, modulo 2^AWIDTH.
  - JZ: TARGET if Z=1 else PC+1; JNZ: TARGET if Z=0 else PC+1.
  - CALL: if SP<DEPTH push PC+1, PC←TARGET, SP+1; if SP==DEPTH no push, PC holds, → FAULT.
  - RET: if SP>0 PC←top entry, pop, SP−1; if SP==0 PC holds, → FAULT.
  - HALT: PC holds, → HALT.
- HALT, EN=1: RESUME=1 → PC←PC+1, → RUN; RESUME=0 → hold. CMD ignored.
- FAULT: absorbing; PC, SP, stack frozen; only RST_N exits.
- EN=0 in any state: no PC, SP, stack or state change; RESUME ignored.
- PC+1 wraps 2^AWIDTH−1 → 0; push of wrapped return address legal.
- Stack is LIFO; entries above SP are don't-care and never read.

## Timing
- Reset (asynchronous assert, release synchronised by system): PC=RESET_VEC, SP=0, HALTED=0, FAULT=0, stack contents don't-care.
- `CMD`, `TARGET`, `Z` sampled on the rising edge concurrent with the instruction at `PC`; new PC visible after that edge (one instruction per cycle, zero bubble on taken jumps).
- CALL then RET in consecutive cycles: RET sees the just-pushed entry (write-then-read across edge; no bypass needed).
- `HALTED`, `FAULT`, `SP` are registered, change on the same edge as PC.
- FAULT/HALT entry takes effect on the edge sampling the offending command; the faulting PC stays on `PC` for debug.
- RST_N asserted mid-CALL/RET: all state reset immediately, no partial push.
- All outputs glitch-free (driven directly from flops).

## Structure
- Shared package `cpu_pkg`: `CMD_*` localparams (3-bit encodings), state encoding `ST_RUN/ST_HALT/ST_FAULT`.
- Sub-module `cpu_ras`: return-address stack, parameters `WIDTH`, `DEPTH`; ports `CLK`, `RST_N`, `PUSH`, `POP`, `DIN`, `TOS`, `SP`, `FULL`, `EMPTY`; ignores PUSH when FULL, POP when EMPTY.
- `cpu_seq` contains PC register, next-PC mux, adder for JREL, and FSM.

## Test plan
- Reset, 5 cycles NEXT with EN=1 (AWIDTH=8) → PC 0,1,2,3,4,5; SP=0; HALTED=FAULT=0.
- PC=0x10, JREL TARGET=0xFC → PC=0x0C; PC=0xFF, NEXT → PC=0x00.
- JZ 0x40 with Z=0 → PC+1; JZ 0x40 with Z=1 → 0x40; JNZ the inverse.
- CALL nesting (DEPTH=4) from PCs 0x01,0x21,0x31,0x41 → SP=4; RET ×4 returns 0x42,0x32,0x22,0x02; 5th CALL at SP=4 → FAULT=1, PC holds, SP=4.
- RET at SP=0 → FAULT=1, PC unchanged; further CMDs and RESUME ignored until RST_N low → PC=RESET_VEC.
- HALT at PC=0x07 → HALTED=1, PC=0x07 held 10 cycles; RESUME with EN=0 ignored; RESUME with EN=1 → PC=0x08, HALTED=0; EN=0 during JMP → PC unchanged.
